apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB requester that sits directly upstream of the 8-bit register-file APB slave.
- Converts single-beat commands from an internal controller (command/response handshake) into APB SETUP/ACCESS sequences on PSELx/PENABLE/PWRITE/PADDR/PWDATA.
- Waits for PREADY and returns read data or a timeout error.
- Supports back-to-back transfers and bounded wait states.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort (legal range 2..255).

Ports:
- PCLK  in  1  APB clock
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at PCLK rise
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse, transfer finished
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_error  out  1  qualifies rsp_valid; 1 = timeout
- busy  out  1  transfer in progress (state != IDLE)
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready

Behaviour:
- Reset values (async, PRESETn=0): state=IDLE; PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error and timeout counter all 0. cmd_ready=1 one cycle after release; busy=0.
- All outputs are registered. cmd_ready = (state==IDLE) and is decoded from the registered state.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_valid=1 → latch write/addr/wdata into PWRITE/PADDR/PWDATA, PSELx=1, PENABLE=0, go to SETUP.
  - Otherwise PSELx=0 and PENABLE=0.
- SETUP:
  - Always exactly 1 cycle, then PENABLE=1, go to ACCESS, clear the timeout counter.
- ACCESS:
  - PADDR/PWRITE/PWDATA are held stable.
  - PREADY=1 sampled → rsp_valid=1 next cycle, rsp_error=0, rsp_rdata = PWRITE ? 0 : PRDATA; PENABLE=0, PSELx=0, go to IDLE.
  - PREADY=0 and counter==TIMEOUT-1 → rsp_valid=1, rsp_error=1, rsp_rdata=0; PSELx=0, PENABLE=0, go to IDLE.
  - Otherwise increment the counter.
- PREADY is ignored outside ACCESS. The downstream slave holds PREADY=1 for the cycle after completion, so it must not complete a following transfer.
- Nominal timing against the downstream slave (PREADY registered on PSELx&PENABLE):
  - Accept at edge N.
  - SETUP during cycle N+1; ACCESS during cycles N+2 and N+3.
  - PREADY seen high at edge ending N+3.
  - rsp_valid high in cycle N+4.
  - Next command accepted at edge ending N+4, at the earliest.
  - Net throughput: 1 transfer per 4 cycles.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata/rsp_error hold their value until the next response.
- Commands presented while busy are not accepted; cmd_valid may stay high.
- Reset asserted mid-transfer: immediate return to reset values, no response is issued, and the in-flight command is lost.
- Counter width is ceil(log2(TIMEOUT)). No wrap is possible because the abort occurs first.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - ADDR_W/DATA_W default constants
  - default TIMEOUT
- Single module; no sub-module. The timeout counter is inline.

Test Plan:
- Write 0xA5 to addr 0x10 → PSELx=1/PENABLE=0 for 1 cycle, then PENABLE=1 with PADDR=0x10, PWDATA=0xA5, PWRITE=1 until PREADY; rsp_valid pulse with rsp_error=0 and rsp_rdata=0x00.
- Read addr 0x10 after that write → rsp_rdata=0xA5, rsp_error=0, response in cycle N+4.
- Back-to-back: cmd_valid held high for write 0x01→0x20 then read 0x20 → second SETUP starts the cycle after the first rsp_valid; read returns 0x01; PREADY from the first transfer does not terminate the second.
- Timeout: PREADY tied 0, TIMEOUT=4 → exactly 4 ACCESS cycles, then rsp_valid=1, rsp_error=1, rsp_rdata=0, PSELx=0, back in IDLE with cmd_ready=1.
- Reset asserted during ACCESS → PSELx/PENABLE/rsp_valid drop to 0 asynchronously; no rsp_valid after release; the next command completes normally.
- Stalled slave: PREADY low for 3 ACCESS cycles, then high → PADDR/PWDATA stable throughout; single rsp_valid, rsp_error=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default sizes for the APB command master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W  = 8;
    localparam int APB_DATA_W  = 8;
    localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_cmd_master_if.sv
// APB bus bundle between the command master (requester) and a register-file slave.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Turns single-beat commands into APB SETUP/ACCESS transfers and returns one
// response pulse per command, aborting with an error after TIMEOUT ACCESS cycles.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy,
    output apb_state_e        state_dbg,
    apb_cmd_master_if.master  bus
);
    // Handshake: a command transfers on a PCLK rise with cmd_valid & cmd_ready;
    // rsp_valid is a one-cycle pulse with no backpressure, rsp_rdata/rsp_error hold.

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0] paddr_n;
    logic [DATA_W-1:0] pwdata_n, rsp_rdata_n;
    logic              rsp_valid_n, rsp_error_n;

    assign state_dbg = state;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        psel_n      = bus.PSELx;
        penable_n   = bus.PENABLE;
        pwrite_n    = bus.PWRITE;
        paddr_n     = bus.PADDR;
        pwdata_n    = bus.PWDATA;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_error_n = rsp_error;
        case (state)
            IDLE: begin
                psel_n    = 1'b0;
                penable_n = 1'b0;
                // cmd_ready is still low in the first cycle after reset release
                if (cmd_valid && cmd_ready) begin
                    pwrite_n = cmd_write;
                    paddr_n  = cmd_addr;
                    pwdata_n = cmd_wdata;
                    psel_n   = 1'b1;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                cnt_n     = '0;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_valid_n = 1'b1;
                    rsp_error_n = 1'b0;
                    rsp_rdata_n = bus.PWRITE ? '0 : bus.PRDATA;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    state_n     = IDLE;
                end else if (cnt == CNT_LAST) begin
                    rsp_valid_n = 1'b1;
                    rsp_error_n = 1'b1;
                    rsp_rdata_n = '0;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    state_n     = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.PSELx   <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.PWRITE  <= 1'b0;
            bus.PADDR   <= '0;
            bus.PWDATA  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bus.PSELx   <= psel_n;
            bus.PENABLE <= penable_n;
            bus.PWRITE  <= pwrite_n;
            bus.PADDR   <= paddr_n;
            bus.PWDATA  <= pwdata_n;
            rsp_valid   <= rsp_valid_n;
            rsp_rdata   <= rsp_rdata_n;
            rsp_error   <= rsp_error_n;
            // registered copies of the next-state decode keep every output a flop
            cmd_ready   <= (state_n == IDLE);
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: register-file slave with programmable wait states,
// directed and random commands checked against a memory/latency reference model.
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int TO = 4;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_error, busy;
  logic [7:0] rsp_rdata;
  apb_state_e state_dbg;

  apb_cmd_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy), .state_dbg(state_dbg), .bus(bus)
  );

  always #5 PCLK = ~PCLK;

  // slave: PREADY registered on PSELx&PENABLE after `stall` extra cycles, held `linger` more cycles
  bit [7:0] mem [256];
  int stall = 0;
  int linger = 2;
  bit tie_low = 1'b0;
  int wcnt, hold;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.PREADY <= 1'b0;
      bus.PRDATA <= 8'h00;
      wcnt <= 0;
      hold <= 0;
    end else if (bus.PSELx && bus.PENABLE && !bus.PREADY) begin
      if (!tie_low && wcnt == stall) begin
        bus.PREADY <= 1'b1;
        hold <= linger - 1;
        wcnt <= 0;
        if (bus.PWRITE) mem[bus.PADDR] <= bus.PWDATA;
        else bus.PRDATA <= mem[bus.PADDR];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else if (bus.PREADY) begin
      if (hold > 0) hold <= hold - 1;
      else bus.PREADY <= 1'b0;
    end else if (!bus.PSELx) begin
      wcnt <= 0;
    end
  end

  // reference model and scoreboard
  bit [7:0] exp_mem [256];
  logic [8:0] exp_q[$];
  int lat_q[$];
  int checks = 0;
  int errors = 0;
  bit cur_w;
  logic [7:0] cur_a, cur_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns just after the accepting posedge
  task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d,
                       input int st, output int waited);
    bit err;
    stall = st;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    cur_w = w; cur_a = a; cur_d = d;
    err = tie_low || (st + 2 > TO);
    exp_q.push_back({err, (w || err) ? 8'h00 : exp_mem[a]});
    lat_q.push_back(err ? TO + 2 : st + 4);
    if (w && !err) exp_mem[a] = d;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge PCLK);
      waited++;
    end
    chk("accept", {31'b0, cmd_ready}, 32'd1);
    @(posedge PCLK);
  endtask

  task automatic collect(input bit drop_valid);
    logic [8:0] exp;
    int lat_e, lat;
    bit seen;
    exp = exp_q.pop_front();
    lat_e = lat_q.pop_front();
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge PCLK);
      lat++;
      if (lat == 1) begin
        if (drop_valid) cmd_valid = 1'b0;
        chk("setup_sel", {31'b0, bus.PSELx}, 32'd1);
        chk("setup_en", {31'b0, bus.PENABLE}, 32'd0);
        chk("setup_addr", {24'b0, bus.PADDR}, {24'b0, cur_a});
        chk("setup_write", {31'b0, bus.PWRITE}, {31'b0, cur_w});
      end else if (lat < lat_e) begin
        chk("access_sel", {31'b0, bus.PSELx}, 32'd1);
        chk("access_en", {31'b0, bus.PENABLE}, 32'd1);
        chk("hold_addr", {24'b0, bus.PADDR}, {24'b0, cur_a});
        chk("hold_wdata", {24'b0, bus.PWDATA}, {24'b0, cur_d});
        chk("hold_write", {31'b0, bus.PWRITE}, {31'b0, cur_w});
      end
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    chk("rsp_seen", {31'b0, seen}, 32'd1);
    chk("rsp_latency", lat, lat_e);
    chk("rsp_error", {31'b0, rsp_error}, {31'b0, exp[8]});
    chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, exp[7:0]});
    chk("rsp_psel", {31'b0, bus.PSELx}, 32'd0);
    chk("rsp_penable", {31'b0, bus.PENABLE}, 32'd0);
    chk("rsp_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rsp_state", 32'(state_dbg), 32'(IDLE));
  endtask

  // one idle cycle after a response: pulse must be gone, data held
  task automatic after_rsp(input logic [7:0] held);
    @(negedge PCLK);
    chk("pulse_width", {31'b0, rsp_valid}, 32'd0);
    chk("rsp_hold", {24'b0, rsp_rdata}, {24'b0, held});
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w8;
    bit no_rsp;
    logic [7:0] addr_set [4];
    logic [7:0] a, d;
    bit w;
    addr_set[0] = 8'h10; addr_set[1] = 8'h20; addr_set[2] = 8'h33; addr_set[3] = 8'h5A;

    // reset values
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", {31'b0, bus.PSELx}, 32'd0);
    chk("rst_penable", {31'b0, bus.PENABLE}, 32'd0);
    chk("rst_pwrite", {31'b0, bus.PWRITE}, 32'd0);
    chk("rst_paddr", {24'b0, bus.PADDR}, 32'd0);
    chk("rst_pwdata", {24'b0, bus.PWDATA}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
    chk("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    // write then read back
    issue(1'b1, 8'h10, 8'hA5, 0, w8); collect(1'b1); after_rsp(8'h00);
    issue(1'b0, 8'h10, 8'h00, 0, w8); collect(1'b1); after_rsp(8'hA5);

    // back-to-back with cmd_valid held high; lingering PREADY must not end the read
    issue(1'b1, 8'h20, 8'h01, 0, w8); collect(1'b0);
    issue(1'b0, 8'h20, 8'h00, 0, w8);
    chk("b2b_wait", w8, 0);
    collect(1'b1); after_rsp(8'h01);

    // stalled slave: three low ACCESS cycles, then ready
    issue(1'b1, 8'h33, 8'h5C, 2, w8); collect(1'b1); after_rsp(8'h00);
    issue(1'b0, 8'h33, 8'h00, 1, w8); collect(1'b1); after_rsp(8'h5C);

    // timeout with PREADY stuck low: read and a lost write
    tie_low = 1'b1;
    issue(1'b0, 8'h10, 8'h00, 0, w8); collect(1'b1); after_rsp(8'h00);
    issue(1'b1, 8'h10, 8'hEE, 0, w8); collect(1'b1); after_rsp(8'h00);
    tie_low = 1'b0;
    issue(1'b0, 8'h10, 8'h00, 0, w8); collect(1'b1); after_rsp(8'hA5);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1));
      a = addr_set[$urandom_range(0, 3)];
      d = 8'($urandom);
      issue(w, a, d, $urandom_range(0, 2), w8);
      collect(1'b1);
      after_rsp(exp_q.size() == 0 ? rsp_rdata : 8'h00);
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end

    // reset during ACCESS: transfer lost, no response afterwards
    tie_low = 1'b1;
    issue(1'b1, 8'h40, 8'h77, 0, w8);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    repeat (2) @(negedge PCLK);
    chk("pre_rst_access", {31'b0, bus.PENABLE}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", {31'b0, bus.PSELx}, 32'd0);
    chk("mid_rst_penable", {31'b0, bus.PENABLE}, 32'd0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    cmd_valid = 1'b0;
    tie_low = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    no_rsp = 1'b1;
    repeat (6) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0) no_rsp = 1'b0;
    end
    chk("no_rsp_after_rst", {31'b0, no_rsp}, 32'd1);
    issue(1'b0, 8'h40, 8'h00, 0, w8); collect(1'b1); after_rsp(8'h00);
    issue(1'b1, 8'h40, 8'h3C, 1, w8); collect(1'b1); after_rsp(8'h00);
    issue(1'b0, 8'h40, 8'h00, 0, w8); collect(1'b1); after_rsp(8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
